// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory arbiter.
package mem_arb_pkg;

    localparam int LINE_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_I   = 2'd1,
        ST_GNT_D   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_timer.sv
// Granted-transfer watchdog: counts granted cycles and flags the last allowed one.
// TIMEOUT = 0 disables expiry entirely.
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // expired fires during the TIMEOUT-th granted cycle, so the transfer is dropped at its end
    localparam logic [TW-1:0] LIMIT = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TW-1:0] count_reg;
    logic [TW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en && (count_reg != '1)) begin
            count_next = count_reg + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    if (TIMEOUT == 0) begin : g_no_timeout
        assign expired = 1'b0;
    end else begin : g_timeout
        assign expired = en && (count_reg == LIMIT);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one shared memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed D-over-I priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_r,
    input  logic [AW-1:0]     i_mem_addr,
    output logic              i_mem_ready,
    output logic [LINE_W-1:0] i_mem_data,
    input  logic              d_mem_r,
    input  logic              d_mem_w,
    input  logic [AW-1:0]     d_mem_addr,
    input  logic [LINE_W-1:0] d_mem_data_out,
    output logic              d_mem_ready,
    output logic [LINE_W-1:0] d_mem_data,
    output logic              mem_r,
    output logic              mem_w,
    output logic [AW-1:0]     mem_addr,
    output logic [LINE_W-1:0] mem_data_out,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_data,
    output logic [1:0]        grant,
    output logic              arb_err
);

    state_t            state_reg, state_next;
    logic [1:0]        grant_reg, grant_next;
    logic              mem_r_reg, mem_r_next;
    logic              mem_w_reg, mem_w_next;
    logic [AW-1:0]     mem_addr_reg, mem_addr_next;
    logic [LINE_W-1:0] mem_data_reg, mem_data_next;
    logic              arb_err_reg, arb_err_next;

    logic i_req, d_req, pick_i, pick_d;
    logic timer_clr, timer_en, timer_expired;

    assign i_req = i_mem_r;
    assign d_req = d_mem_r | d_mem_w;

`ifdef MEM_ARB_RR_EN
    logic last_d_reg, last_d_next;

    // On a tie, favour whichever side did not win the previous grant
    assign pick_d = d_req && (!i_req || !last_d_reg);

    always_comb begin
        last_d_next = last_d_reg;
        if ((state_reg == ST_IDLE) && (i_req || d_req)) begin
            last_d_next = pick_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_reg <= 1'b1;
        end else begin
            last_d_reg <= last_d_next;
        end
    end
`else
    assign pick_d = d_req;
`endif

    assign pick_i = i_req && !pick_d;

    mem_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(timer_expired)
    );

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        mem_r_next    = mem_r_reg;
        mem_w_next    = mem_w_reg;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;
        arb_err_next  = arb_err_reg;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (pick_d) begin
                    state_next    = ST_GNT_D;
                    grant_next    = GNT_D;
                    // a simultaneous read+write is a writeback; the refill comes as its own transfer
                    mem_r_next    = d_mem_r & ~d_mem_w;
                    mem_w_next    = d_mem_w;
                    mem_addr_next = d_mem_addr;
                    mem_data_next = d_mem_data_out;
                    timer_clr     = 1'b1;
                end else if (pick_i) begin
                    state_next    = ST_GNT_I;
                    grant_next    = GNT_I;
                    mem_r_next    = 1'b1;
                    mem_w_next    = 1'b0;
                    mem_addr_next = i_mem_addr;
                    mem_data_next = '0;
                    timer_clr     = 1'b1;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                timer_en = 1'b1;
                // a completion in the final allowed cycle still counts as success
                if (mem_ready || timer_expired) begin
                    state_next = ST_RECOVER;
                    grant_next = GNT_NONE;
                    mem_r_next = 1'b0;
                    mem_w_next = 1'b0;
                    if (!mem_ready) begin
                        arb_err_next = 1'b1;
                    end
                end
            end
            ST_RECOVER: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= GNT_NONE;
            mem_r_reg    <= 1'b0;
            mem_w_reg    <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            arb_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            mem_r_reg    <= mem_r_next;
            mem_w_reg    <= mem_w_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
            arb_err_reg  <= arb_err_next;
        end
    end

    assign grant        = grant_reg;
    assign mem_r        = mem_r_reg;
    assign mem_w        = mem_w_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_data_out = mem_data_reg;
    assign arb_err      = arb_err_reg;

    assign i_mem_ready  = mem_ready && (state_reg == ST_GNT_I);
    assign d_mem_ready  = mem_ready && (state_reg == ST_GNT_D);
    assign i_mem_data   = mem_data;
    assign d_mem_data   = mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT = 4); honours MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_mem_r;
    logic [AW-1:0] i_mem_addr;
    logic          i_mem_ready;
    logic [LW-1:0] i_mem_data;
    logic          d_mem_r;
    logic          d_mem_w;
    logic [AW-1:0] d_mem_addr;
    logic [LW-1:0] d_mem_data_out;
    logic          d_mem_ready;
    logic [LW-1:0] d_mem_data;
    logic          mem_r;
    logic          mem_w;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_data_out;
    logic          mem_ready;
    logic [LW-1:0] mem_data;
    logic [1:0]    grant;
    logic          arb_err;

    int checks = 0;
    int errors = 0;
    bit model_last_d = 1'b1;
    bit model_err    = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .TIMEOUT(TO),
        .AW     (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_mem_r       (i_mem_r),
        .i_mem_addr    (i_mem_addr),
        .i_mem_ready   (i_mem_ready),
        .i_mem_data    (i_mem_data),
        .d_mem_r       (d_mem_r),
        .d_mem_w       (d_mem_w),
        .d_mem_addr    (d_mem_addr),
        .d_mem_data_out(d_mem_data_out),
        .d_mem_ready   (d_mem_ready),
        .d_mem_data    (d_mem_data),
        .mem_r         (mem_r),
        .mem_w         (mem_w),
        .mem_addr      (mem_addr),
        .mem_data_out  (mem_data_out),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data),
        .grant         (grant),
        .arb_err       (arb_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Arbitration rule: who wins among the currently pending requesters
    function automatic logic [1:0] exp_winner(input bit ireq, input bit dreq);
        if (ireq && dreq) begin
`ifdef MEM_ARB_RR_EN
            return model_last_d ? 2'b01 : 2'b10;
`else
            return 2'b10;
`endif
        end
        if (dreq) return 2'b10;
        if (ireq) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        i_mem_r = 1'b1; i_mem_addr = 32'h1111_0000;
        d_mem_r = 1'b0; d_mem_w = 1'b1; d_mem_addr = 32'h2222_0000;
        d_mem_data_out = rand_line();
        mem_ready = 1'b1; mem_data = rand_line();
        #2;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({grant, mem_r, mem_w, mem_addr, mem_data_out, arb_err, i_mem_ready, d_mem_ready} !== '0) begin
                errors++;
                $display("FAIL reset_hold: got grant=%b r=%b w=%b addr=%h dout=%h err=%b ir=%b dr=%b, expected all zero",
                         grant, mem_r, mem_w, mem_addr, mem_data_out, arb_err, i_mem_ready, d_mem_ready);
            end
            tick();
        end
        i_mem_r = 1'b0; d_mem_w = 1'b0; mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got grant=%b, expected 00", grant);
        end
        tick();
        checks++;
        if ({grant, mem_r, arb_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got grant=%b r=%b err=%b, expected 00 0 0", grant, mem_r, arb_err);
        end
        $display("txn reset done");
    endtask

    task automatic test_i_read();
        logic [LW-1:0] md;
        i_mem_r = 1'b1; i_mem_addr = 32'h0000_1230;
        #1;
        checks++;
        if ({grant, mem_r} !== 3'b000) begin
            errors++;
            $display("FAIL i_read_pre: got grant=%b r=%b, expected 00 0", grant, mem_r);
        end
        tick();
        checks++;
        if ({grant, mem_r, mem_w, mem_addr, mem_data_out} !== {2'b01, 1'b1, 1'b0, 32'h0000_1230, {LW{1'b0}}}) begin
            errors++;
            $display("FAIL i_read_grant: got grant=%b r=%b w=%b addr=%h dout=%h, expected 01 1 0 00001230 0",
                     grant, mem_r, mem_w, mem_addr, mem_data_out);
        end
        model_last_d = 1'b0;
        tick();
        checks++;
        if ({grant, i_mem_ready, d_mem_ready} !== 4'b0100) begin
            errors++;
            $display("FAIL i_read_wait: got grant=%b ir=%b dr=%b, expected 01 0 0", grant, i_mem_ready, d_mem_ready);
        end
        tick();
        md = rand_line();
        mem_data = md; mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_mem_ready, d_mem_ready, i_mem_data, grant} !== {1'b1, 1'b0, md, 2'b01}) begin
            errors++;
            $display("FAIL i_read_ready: got ir=%b dr=%b data=%h grant=%b, expected 1 0 %h 01",
                     i_mem_ready, d_mem_ready, i_mem_data, grant, md);
        end
        tick();
        mem_ready = 1'b0; i_mem_r = 1'b0;
        checks++;
        if ({grant, mem_r} !== 3'b000) begin
            errors++;
            $display("FAIL i_read_recover: got grant=%b r=%b, expected 00 0", grant, mem_r);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_mem_ready, d_mem_ready} !== 2'b00) begin
            errors++;
            $display("FAIL stray_ready_recover: got ir=%b dr=%b, expected 0 0", i_mem_ready, d_mem_ready);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL i_read_idle: got grant=%b, expected 00", grant);
        end
        $display("txn i_read addr 00001230 lat 3");
    endtask

    task automatic test_tie();
        logic [1:0]    w;
        logic [AW-1:0] ia, da;
        logic [LW-1:0] md;
        ia = 32'h0000_4000; da = 32'h0000_8000;
        i_mem_r = 1'b1; i_mem_addr = ia;
        d_mem_r = 1'b1; d_mem_w = 1'b0; d_mem_addr = da; d_mem_data_out = rand_line();
        for (int k = 0; k < 2; k++) begin
            w = exp_winner(i_mem_r, d_mem_r | d_mem_w);
            tick();
            checks++;
            if ({grant, mem_r, mem_w, mem_addr} !== {w, 1'b1, 1'b0, (w == 2'b10) ? da : ia}) begin
                errors++;
                $display("FAIL tie_grant%0d: got grant=%b r=%b w=%b addr=%h, expected %b 1 0 %h",
                         k, grant, mem_r, mem_w, mem_addr, w, (w == 2'b10) ? da : ia);
            end
            model_last_d = (w == 2'b10);
            md = rand_line();
            mem_data = md; mem_ready = 1'b1;
            #1;
            checks++;
            if ({i_mem_ready, d_mem_ready} !== {w[0], w[1]}) begin
                errors++;
                $display("FAIL tie_ready%0d: got ir=%b dr=%b, expected %b %b", k, i_mem_ready, d_mem_ready, w[0], w[1]);
            end
            $display("txn tie %0d grant %b", k, w);
            tick();
            mem_ready = 1'b0;
            if (w == 2'b10) d_mem_r = 1'b0; else i_mem_r = 1'b0;
            checks++;
            if (grant !== 2'b00) begin
                errors++;
                $display("FAIL tie_recover%0d: got grant=%b, expected 00", k, grant);
            end
            tick();
        end
    endtask

    task automatic test_d_write_refill();
        logic [AW-1:0] a;
        logic [LW-1:0] a5;
        a  = 32'h8000_0040;
        a5 = {16{8'hA5}};
        d_mem_w = 1'b1; d_mem_r = 1'b0; d_mem_addr = a; d_mem_data_out = a5;
        tick();
        checks++;
        if ({grant, mem_r, mem_w, mem_addr, mem_data_out} !== {2'b10, 1'b0, 1'b1, a, a5}) begin
            errors++;
            $display("FAIL wb_grant: got grant=%b r=%b w=%b addr=%h dout=%h, expected 10 0 1 %h %h",
                     grant, mem_r, mem_w, mem_addr, mem_data_out, a, a5);
        end
        model_last_d = 1'b1;
        d_mem_addr = 32'hDEAD_BEEF; d_mem_data_out = '0;
        tick();
        checks++;
        if ({mem_w, mem_addr, mem_data_out} !== {1'b1, a, a5}) begin
            errors++;
            $display("FAIL wb_stable: got w=%b addr=%h dout=%h, expected 1 %h %h", mem_w, mem_addr, mem_data_out, a, a5);
        end
        mem_ready = 1'b1; mem_data = rand_line();
        #1;
        checks++;
        if ({d_mem_ready, i_mem_ready} !== 2'b10) begin
            errors++;
            $display("FAIL wb_ready: got dr=%b ir=%b, expected 1 0", d_mem_ready, i_mem_ready);
        end
        tick();
        mem_ready = 1'b0;
        d_mem_w = 1'b0; d_mem_r = 1'b1; d_mem_addr = a;
        checks++;
        if ({grant, mem_w} !== 3'b000) begin
            errors++;
            $display("FAIL wb_recover: got grant=%b w=%b, expected 00 0", grant, mem_w);
        end
        tick();
        tick();
        checks++;
        if ({grant, mem_r, mem_w, mem_addr} !== {2'b10, 1'b1, 1'b0, a}) begin
            errors++;
            $display("FAIL refill_grant: got grant=%b r=%b w=%b addr=%h, expected 10 1 0 %h", grant, mem_r, mem_w, mem_addr, a);
        end
        mem_ready = 1'b1; mem_data = rand_line();
        #1;
        checks++;
        if (d_mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL refill_ready: got dr=%b, expected 1", d_mem_ready);
        end
        $display("txn d_write_refill addr %h", a);
        tick();
        mem_ready = 1'b0; d_mem_r = 1'b0;
        tick();
    endtask

    task automatic test_rw_both();
        logic [AW-1:0] a;
        logic [LW-1:0] dd;
        a = $urandom(); dd = rand_line();
        d_mem_r = 1'b1; d_mem_w = 1'b1; d_mem_addr = a; d_mem_data_out = dd;
        tick();
        checks++;
        if ({grant, mem_r, mem_w, mem_addr, mem_data_out} !== {2'b10, 1'b0, 1'b1, a, dd}) begin
            errors++;
            $display("FAIL rw_both: got grant=%b r=%b w=%b addr=%h dout=%h, expected 10 0 1 %h %h",
                     grant, mem_r, mem_w, mem_addr, mem_data_out, a, dd);
        end
        model_last_d = 1'b1;
        mem_ready = 1'b1; mem_data = rand_line();
        #1;
        checks++;
        if (d_mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL rw_both_ready: got dr=%b, expected 1", d_mem_ready);
        end
        $display("txn rw_both addr %h", a);
        tick();
        mem_ready = 1'b0; d_mem_r = 1'b0; d_mem_w = 1'b0;
        tick();
    endtask

    task automatic test_random(input int rounds);
        logic [1:0]    w;
        logic          er, ew;
        logic [AW-1:0] ea;
        logic [LW-1:0] ed, md;
        int            lat, dk;
        for (int r = 0; r < rounds; r++) begin
            i_mem_r = 1'($urandom_range(0, 1));
            dk = $urandom_range(0, 3);
            if (!i_mem_r && dk == 0) i_mem_r = 1'b1;
            d_mem_r = dk[0]; d_mem_w = dk[1];
            i_mem_addr = $urandom(); d_mem_addr = $urandom(); d_mem_data_out = rand_line();
            for (int k = 0; k < 2; k++) begin
                if (!(i_mem_r || d_mem_r || d_mem_w)) break;
                w = exp_winner(i_mem_r, d_mem_r | d_mem_w);
                if (w == 2'b10) begin
                    er = d_mem_r & ~d_mem_w; ew = d_mem_w; ea = d_mem_addr; ed = d_mem_data_out;
                end else begin
                    er = 1'b1; ew = 1'b0; ea = i_mem_addr; ed = '0;
                end
                tick();
                checks++;
                if ({grant, mem_r, mem_w, mem_addr, mem_data_out, arb_err} !== {w, er, ew, ea, ed, model_err}) begin
                    errors++;
                    $display("FAIL rnd_grant: got grant=%b r=%b w=%b addr=%h dout=%h err=%b, expected %b %b %b %h %h %b",
                             grant, mem_r, mem_w, mem_addr, mem_data_out, arb_err, w, er, ew, ea, ed, model_err);
                end
                model_last_d = (w == 2'b10);
                if (w == 2'b10) begin
                    d_mem_addr = $urandom(); d_mem_data_out = rand_line();
                end else begin
                    i_mem_addr = $urandom();
                end
                lat = $urandom_range(1, TO);
                for (int c = 1; c < lat; c++) tick();
                md = rand_line();
                mem_data = md; mem_ready = 1'b1;
                #1;
                checks++;
                if ({i_mem_ready, d_mem_ready, i_mem_data, d_mem_data, mem_r, mem_w, mem_addr, mem_data_out} !==
                    {w[0], w[1], md, md, er, ew, ea, ed}) begin
                    errors++;
                    $display("FAIL rnd_ready: got ir=%b dr=%b idata=%h r=%b w=%b addr=%h, expected %b %b %h %b %b %h",
                             i_mem_ready, d_mem_ready, i_mem_data, mem_r, mem_w, mem_addr, w[0], w[1], md, er, ew, ea);
                end
                $display("txn rnd %0d.%0d grant %b r %b w %b addr %h lat %0d last_d %0d", r, k, w, er, ew, ea, lat, model_last_d);
                tick();
                mem_ready = 1'b0;
                if (w == 2'b10) begin
                    d_mem_r = 1'b0; d_mem_w = 1'b0;
                end else begin
                    i_mem_r = 1'b0;
                end
                checks++;
                if ({grant, mem_r, mem_w, arb_err} !== {2'b00, 1'b0, 1'b0, model_err}) begin
                    errors++;
                    $display("FAIL rnd_recover: got grant=%b r=%b w=%b err=%b, expected 00 0 0 %b", grant, mem_r, mem_w, arb_err, model_err);
                end
                tick();
            end
        end
    endtask

    task automatic test_timeout();
        logic [AW-1:0] a;
        a = $urandom();
        i_mem_r = 1'b1; i_mem_addr = a;
        for (int c = 1; c <= TO; c++) begin
            tick();
            checks++;
            if ({grant, mem_r, i_mem_ready, arb_err} !== {2'b01, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL timeout_hold%0d: got grant=%b r=%b ir=%b err=%b, expected 01 1 0 0", c, grant, mem_r, i_mem_ready, arb_err);
            end
        end
        model_last_d = 1'b0;
        tick();
        model_err = 1'b1;
        checks++;
        if ({grant, mem_r, mem_w, arb_err, i_mem_ready, d_mem_ready} !== {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_expire: got grant=%b r=%b w=%b err=%b ir=%b dr=%b, expected 00 0 0 1 0 0",
                     grant, mem_r, mem_w, arb_err, i_mem_ready, d_mem_ready);
        end
        i_mem_r = 1'b0;
        tick();
        a = $urandom();
        i_mem_r = 1'b1; i_mem_addr = a;
        tick();
        checks++;
        if ({grant, mem_r, mem_addr, arb_err} !== {2'b01, 1'b1, a, 1'b1}) begin
            errors++;
            $display("FAIL timeout_next_grant: got grant=%b r=%b addr=%h err=%b, expected 01 1 %h 1", grant, mem_r, mem_addr, arb_err, a);
        end
        tick();
        mem_ready = 1'b1; mem_data = rand_line();
        #1;
        checks++;
        if ({i_mem_ready, arb_err} !== 2'b11) begin
            errors++;
            $display("FAIL timeout_next_ready: got ir=%b err=%b, expected 1 1", i_mem_ready, arb_err);
        end
        $display("txn timeout then served addr %h", a);
        tick();
        mem_ready = 1'b0; i_mem_r = 1'b0;
        tick();
        checks++;
        if (arb_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b, expected 1", arb_err);
        end
    endtask

    task automatic test_reset_mid();
        d_mem_r = 1'b1; d_mem_w = 1'b0; d_mem_addr = $urandom(); d_mem_data_out = rand_line();
        tick();
        checks++;
        if (grant !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_grant: got grant=%b, expected 10", grant);
        end
        tick();
        rst = 1'b0;
        #1;
        model_last_d = 1'b1;
        model_err = 1'b0;
        checks++;
        if ({grant, mem_r, mem_w, mem_addr, mem_data_out, arb_err} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got grant=%b r=%b w=%b addr=%h dout=%h err=%b, expected all zero",
                     grant, mem_r, mem_w, mem_addr, mem_data_out, arb_err);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({d_mem_ready, i_mem_ready} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_ready_in_reset: got dr=%b ir=%b, expected 0 0", d_mem_ready, i_mem_ready);
        end
        d_mem_r = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({grant, d_mem_ready, i_mem_ready, arb_err} !== 5'b0) begin
                errors++;
                $display("FAIL rstmid_after%0d: got grant=%b dr=%b ir=%b err=%b, expected 00 0 0 0", c, grant, d_mem_ready, i_mem_ready, arb_err);
            end
            tick();
        end
        mem_ready = 1'b0;
        $display("txn reset mid-transfer");
    endtask

    initial begin
        rst = 1'b0;
        i_mem_r = 1'b0; i_mem_addr = '0;
        d_mem_r = 1'b0; d_mem_w = 1'b0; d_mem_addr = '0; d_mem_data_out = '0;
        mem_ready = 1'b0; mem_data = '0;
        test_reset();
        test_i_read();
        test_tie();
        test_d_write_refill();
        test_rw_both();
        test_random(40);
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
